inst_ram_256x8: RTL and testbench

- Instruction memory for the pipelined RISC core: 256 bytes of byte-addressable storage, read as 32-bit big-endian words.
- Sits in the fetch stage. The PC drives `address`, and `data_out` feeds the IF/ID instruction register.
- A byte-wide load port lets a bench or boot loader fill the array. The array is also reachable hierarchically as `mem` for backdoor preload.

---
 rtl/inst_ram_256x8.sv | 74 +++++++
 tb/tb_inst_ram_256x8.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/inst_ram_256x8.sv
// Byte-addressable instruction memory read as 32-bit big-endian words.
// One-cycle registered fetch with wrap-around indexing, plus a byte-wide load port.
`timescale 1ns/1ps
module inst_ram_256x8 #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [31:0]   address,
    output logic [31:0]   data_out,
    output logic          valid,
    output logic          addr_err,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [7:0]    load_data
);

    logic [7:0]    mem [0:DEPTH-1];

    logic [AW-1:0] rd_idx;
    logic [7:0]    rd_byte [0:3];

    logic [31:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;

    assign rd_idx = address[AW-1:0];

    // Lane gi reads byte i+gi; the AW-bit add wraps modulo DEPTH.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [AW-1:0] lane_idx;
            assign lane_idx    = rd_idx + AW'(gi);
            assign rd_byte[gi] = mem[lane_idx];
        end
    endgenerate

    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = err_q;
        if (enable) begin
            data_d  = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
            valid_d = 1'b1;
            err_d   = |address[31:AW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= 32'h0000_0000;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Contents survive reset; a read on the same edge sees the old byte.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    assign data_out = data_q;
    assign valid    = valid_q;
    assign addr_err = err_q;

endmodule

// File: tb/tb_inst_ram_256x8.sv
// Directed and randomized checks of inst_ram_256x8 against a byte-array reference model.
`timescale 1ns/1ps
module tb_inst_ram_256x8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [31:0] address;
    logic [31:0] data_out;
    logic        valid;
    logic        addr_err;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [7:0]  load_data;

    int tests = 0;
    int fails = 0;

    logic [7:0]  ref_mem [256];
    logic [31:0] exp_data;
    logic        exp_valid;
    logic        exp_err;

    inst_ram_256x8 #(.DEPTH(256), .AW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .address   (address),
        .data_out  (data_out),
        .valid     (valid),
        .addr_err  (addr_err),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within time budget");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int i;
        i = int'(a % 32'd256);
        return {ref_mem[i], ref_mem[(i + 1) % 256], ref_mem[(i + 2) % 256], ref_mem[(i + 3) % 256]};
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, predict from the model (read sees old bytes), then check.
    task automatic cycle(input logic en, input logic [31:0] addr,
                         input logic ld, input logic [7:0] la, input logic [7:0] ldd);
        enable    = en;
        address   = addr;
        load_en   = ld;
        load_addr = la;
        load_data = ldd;
        if (en) begin
            exp_data = ref_word(addr);
            exp_err  = (addr / 32'd256) != 32'd0;
        end
        exp_valid = en;
        @(posedge clk);
        #1;
        if (ld) ref_mem[la] = ldd;
        enable  = 1'b0;
        load_en = 1'b0;
        check32("data", data_out, exp_data);
        check1("valid", valid, exp_valid);
        check1("addr_err", addr_err, exp_err);
    endtask

    initial begin
        rst_n     = 1'b1;
        enable    = 1'b0;
        address   = 32'h0;
        load_en   = 1'b0;
        load_addr = 8'h0;
        load_data = 8'h0;
        exp_data  = 32'h0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;

        // Asynchronous reset at start, checked before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check32("reset_data", data_out, 32'h0);
        check1("reset_valid", valid, 1'b0);
        check1("reset_err", addr_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill: bytes 0..15 hold their index, the rest random
        for (int k = 0; k < 256; k++) begin
            cycle(1'b0, 32'h0, 1'b1, 8'(k), (k < 16) ? 8'(k) : 8'($urandom_range(0, 255)));
        end

        // Test 1: aligned back-to-back reads
        cycle(1'b1, 32'd0, 1'b0, 8'h0, 8'h0);
        check32("t1_w0", data_out, 32'h00010203);
        cycle(1'b1, 32'd4, 1'b0, 8'h0, 8'h0);
        check32("t1_w4", data_out, 32'h04050607);
        cycle(1'b1, 32'd8, 1'b0, 8'h0, 8'h0);
        check32("t1_w8", data_out, 32'h08090A0B);
        cycle(1'b1, 32'd12, 1'b0, 8'h0, 8'h0);
        check32("t1_w12", data_out, 32'h0C0D0E0F);

        // Test 3: misaligned read and upper-bit aliasing
        cycle(1'b1, 32'd1, 1'b0, 8'h0, 8'h0);
        check32("t3_mis1", data_out, 32'h01020304);
        cycle(1'b1, 32'h0000_0104, 1'b0, 8'h0, 8'h0);
        check32("t3_alias", data_out, 32'h04050607);
        check1("t3_alias_err", addr_err, 1'b1);

        // Test 4: idle cycles hold data, drop valid
        cycle(1'b1, 32'd0, 1'b0, 8'h0, 8'h0);
        check1("t4_err_clear", addr_err, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 32'd40, 1'b0, 8'h0, 8'h0);
            check32("t4_hold", data_out, 32'h00010203);
            check1("t4_valid_low", valid, 1'b0);
        end

        // Test 5: same-edge load and read of the same byte
        cycle(1'b1, 32'd4, 1'b1, 8'd4, 8'h77);
        check32("t5_old", data_out, 32'h04050607);
        cycle(1'b1, 32'd4, 1'b0, 8'h0, 8'h0);
        check32("t5_new", data_out, 32'h77050607);

        // Test 6: reset asserted between edges clears outputs immediately
        cycle(1'b1, 32'h0000_0208, 1'b0, 8'h0, 8'h0);
        #3 rst_n = 1'b0;
        #1;
        check32("t6_async_data", data_out, 32'h0);
        check1("t6_async_valid", valid, 1'b0);
        check1("t6_async_err", addr_err, 1'b0);
        enable  = 1'b1;
        address = 32'd8;
        @(posedge clk);
        #1;
        check32("t6_held_data", data_out, 32'h0);
        check1("t6_held_valid", valid, 1'b0);
        enable = 1'b0;
        #3 rst_n = 1'b1;
        exp_data  = 32'h0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b1, 32'd0, 1'b0, 8'h0, 8'h0);
        check32("t6_retained", data_out, 32'h00010203);

        // Test 2: wrap-around read at the top byte
        cycle(1'b0, 32'h0, 1'b1, 8'd255, 8'hAA);
        cycle(1'b0, 32'h0, 1'b1, 8'd0, 8'hBB);
        cycle(1'b0, 32'h0, 1'b1, 8'd1, 8'hCC);
        cycle(1'b0, 32'h0, 1'b1, 8'd2, 8'hDD);
        cycle(1'b1, 32'd255, 1'b0, 8'h0, 8'h0);
        check32("t2_wrap", data_out, 32'hAABBCCDD);

        // Randomized mix of reads, idles and loads
        for (int k = 0; k < 300; k++) begin
            logic [31:0] ra;
            ra = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
            cycle(($urandom_range(0, 3) != 0), ra,
                  ($urandom_range(0, 1) == 1), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
